// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and slave register map.
package apb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS
  } apb_state_e;

  localparam logic [31:0] ADDR_DATA1 = 32'h1000;
  localparam logic [31:0] ADDR_DATA2 = 32'h1004;
  localparam logic [31:0] ADDR_DATA3 = 32'h1008;

endpackage

// File: rtl/apb_gpio_master_arb_rr_arbiter.sv
// Combinational round-robin arbiter: scans from i_ptr upward (wrapping) and
// grants the first active request. Outputs are don't-care when i_req is 0.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W:0] NREQ_V = (IDX_W+1)'(NREQ);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Priority scan starting at the pointer; the sum is reduced modulo NREQ so
  // non-power-of-two requester counts wrap correctly.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_sum >= NREQ_V) w_sum = w_sum - NREQ_V;
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/apb_gpio_master_arb.sv
// Round-robin APB master sharing one APB slave among NREQ requesters.
// Arbitrates in IDLE, runs SETUP/ACCESS, returns read data with a one-cycle
// done pulse, and aborts with err if the slave stalls for TIMEOUT cycles.
//
// state  | meaning
// IDLE   | bus idle; arbitrate and latch the winner's request
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1; wait for PREADY or timeout
module apb_gpio_master_arb
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic [ADDR_W-1:0]        PADDR,
  output logic                     PWRITE,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY
);

  localparam int IDX_W = $clog2(NREQ);
  // Wide enough to hold TIMEOUT itself; one bit when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  logic [NREQ-1:0]  w_arb_gnt;
  logic [IDX_W-1:0] w_arb_idx;

  apb_state_e        r_state,   w_state_nxt;
  logic [IDX_W-1:0]  r_idx,     w_idx_nxt;
  logic [IDX_W-1:0]  r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [NREQ-1:0]   r_gnt,     w_gnt_nxt;
  logic [NREQ-1:0]   r_done,    w_done_nxt;
  logic              r_err,     w_err_nxt;
  logic [DATA_W-1:0] r_rdata,   w_rdata_nxt;
  logic              r_psel,    w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic [ADDR_W-1:0] r_paddr,   w_paddr_nxt;
  logic              r_pwrite,  w_pwrite_nxt;
  logic [DATA_W-1:0] r_pwdata,  w_pwdata_nxt;

  logic [IDX_W-1:0]  w_ptr_inc;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_ptr_inc = (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_done_nxt    = '0;
    w_err_nxt     = 1'b0;
    w_rdata_nxt   = r_rdata;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_paddr_nxt   = r_paddr;
    w_pwrite_nxt  = r_pwrite;
    w_pwdata_nxt  = r_pwdata;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt   = S_SETUP;
          w_idx_nxt     = w_arb_idx;
          w_gnt_nxt     = w_arb_gnt;
          w_paddr_nxt   = w_addr[w_arb_idx];
          w_pwrite_nxt  = req_write[w_arb_idx];
          w_pwdata_nxt  = w_wdata[w_arb_idx];
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        if (PREADY) begin
          if (!r_pwrite) w_rdata_nxt = PRDATA;
          w_done_nxt    = r_gnt;
          w_ptr_nxt     = w_ptr_inc;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_gnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
        end else if (w_timeout) begin
          w_done_nxt    = r_gnt;
          w_err_nxt     = 1'b1;
          w_ptr_nxt     = w_ptr_inc;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_gnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
        end else if (TIMEOUT != 0) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_gnt_nxt     = '0;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_pwdata  <= w_pwdata_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_gpio_master_arb.sv
// Bench for apb_gpio_master_arb: APB slave model with a write-recovery wait
// state, directed scenarios, then randomized traffic against a
// transaction-level model of round-robin arbitration and register contents.
module tb_apb_gpio_master_arb;
  import apb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NR-1:0]     req, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt, done;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              PSEL, PENABLE, PWRITE;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;

  bit stuck, rand_waits;
  int n_tests, n_fail;

  apb_gpio_master_arb #(.NREQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int map_idx(input logic [31:0] a);
    case (a)
      ADDR_DATA1: return 0;
      ADDR_DATA2: return 1;
      ADDR_DATA3: return 2;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // APB slave: three registers, unmapped reads return 0, one wait state on
  // the first ACCESS after a write, optional random waits or a stuck PREADY.
  logic [31:0] smem [3];
  bit s_acc_on, s_wr_pend;
  int s_wl;
  initial begin
    smem[0] = 32'h0; smem[1] = 32'hF1; smem[2] = 32'h0;
    PREADY = 1'b0; PRDATA = '0; s_acc_on = 0; s_wr_pend = 0; s_wl = 0;
    forever begin
      @(posedge PCLK);
      if (!PRESET && PSEL && PENABLE) begin
        if (PREADY) begin
          if (PWRITE) begin
            if (map_idx(PADDR) >= 0) smem[map_idx(PADDR)] = PWDATA;
            s_wr_pend = 1;
          end
          s_acc_on = 0;
        end else if (s_wl > 0) begin
          s_wl--;
        end
      end
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        if (!s_acc_on) begin
          s_acc_on  = 1;
          s_wl      = (s_wr_pend ? 1 : 0) + (rand_waits ? int'($urandom_range(0, 2)) : 0);
          s_wr_pend = 0;
        end
        PREADY = !stuck && (s_wl == 0);
      end else begin
        s_acc_on = 0;
        PREADY   = 1'b0;
      end
      PRDATA = (map_idx(PADDR) >= 0) ? smem[map_idx(PADDR)] : 32'h0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-requester transfer; lat counts negedges from the accepting edge to done.
  task automatic xfer(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output bit e, output int lat, output int acc,
                      output bit ph_ok);
    @(negedge PCLK);
    req_write[idx] = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
    req[idx] = 1'b1;
    lat = 0; acc = 0; ph_ok = 1; rd = '0; e = 0;
    do begin
      @(negedge PCLK);
      lat++;
      if (lat == 1 && !(PSEL && !PENABLE)) ph_ok = 0;
      if (lat == 2 && !(PSEL && PENABLE)) ph_ok = 0;
      if (PSEL && PENABLE) acc++;
    end while (done[idx] !== 1'b1 && lat < 100);
    rd = rdata;
    e  = err;
    req[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, output bit ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge PCLK);
      if (done[idx] === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  bit e, ph, ok, twohot;
  int lat, acc;
  logic [NR-1:0] gq [$];
  logic [NR-1:0] dq [$];
  logic [31:0]   rq [$];
  logic [NR-1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0]   exp_r [4] = '{32'hA5, 32'hF1, 32'hA5, 32'hF1};

  // Randomized-phase reference model state.
  logic [31:0] ref_mem [3];
  bit t_wr [NR];
  logic [31:0] t_addr [NR], t_wd [NR];
  bit busy, stopping;
  int cur_win, ptr_m, viol, maxwait, n_xfer, win, c, m;
  int waitc [NR];

  task automatic new_txn(input int i);
    case ($urandom_range(0, 3))
      0:       t_addr[i] = ADDR_DATA1;
      1:       t_addr[i] = ADDR_DATA2;
      2:       t_addr[i] = ADDR_DATA3;
      default: t_addr[i] = 32'h2000;
    endcase
    t_wr[i] = 1'($urandom_range(0, 1));
    t_wd[i] = $urandom;
    req_write[i] = t_wr[i];
    req_addr[i*AW +: AW]  = t_addr[i];
    req_wdata[i*DW +: DW] = t_wd[i];
    req[i] = 1'b1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; stuck = 0; rand_waits = 0;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    chk("rst_apb",   {PSEL, PENABLE, PWRITE}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_gnt",   gnt, 0);
    chk("rst_done",  {done, err}, 0);
    chk("rst_rdata", rdata, 0);
    PRESET = 1'b0;

    // Read after reset: SETUP, ACCESS, done with the slave's reset value.
    xfer(0, 0, ADDR_DATA2, 0, rd, e, lat, acc, ph);
    chk("t1_phase", ph, 1);
    chk("t1_lat",   lat, 3);
    chk("t1_done",  done, 2'b01);
    chk("t1_rdata", rd, 32'hF1);
    chk("t1_err",   e, 0);

    // Write then read back; the read absorbs the slave's recovery wait state.
    xfer(0, 1, ADDR_DATA1, 32'hA5, rd, e, lat, acc, ph);
    chk("t2_wlat",   lat, 3);
    chk("t2_werr",   e, 0);
    chk("t2_rdhold", rd, 32'hF1);
    xfer(0, 0, ADDR_DATA1, 0, rd, e, lat, acc, ph);
    chk("t2_rlat",   lat, 4);
    chk("t2_rdata",  rd, 32'hA5);
    chk("t2_rerr",   e, 0);

    // Requester 1 alone, which leaves the pointer at 0.
    xfer(1, 0, ADDR_DATA3, 0, rd, e, lat, acc, ph);
    chk("t2b_done",  done, 2'b10);
    chk("t2b_rdata", rd, 32'h0);

    // Both requesters held high: grants alternate starting at 0.
    @(negedge PCLK);
    req_write = '0;
    req_addr  = {ADDR_DATA2, ADDR_DATA1};
    req = 2'b11;
    twohot = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge PCLK);
      if ($countones(gnt) > 1) twohot = 1;
      if (PSEL && !PENABLE) gq.push_back(gnt);
      if (done != 0) begin
        dq.push_back(done);
        rq.push_back(rdata);
        if (dq.size() == 4) begin
          req = '0;
          break;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_gnt%0d", k),   (k < gq.size()) ? gq[k] : 2'b00, exp_g[k]);
      chk($sformatf("t3_done%0d", k),  (k < dq.size()) ? dq[k] : 2'b00, exp_g[k]);
      chk($sformatf("t3_rdata%0d", k), (k < rq.size()) ? rq[k] : 32'h0, exp_r[k]);
    end
    chk("t3_onehot", twohot, 0);

    // Stuck slave: 16 ACCESS wait cycles, then done+err with rdata held.
    stuck = 1;
    xfer(0, 0, ADDR_DATA1, 0, rd, e, lat, acc, ph);
    stuck = 0;
    chk("t4_lat",   lat, 18);
    chk("t4_acc",   acc, 16);
    chk("t4_done",  done, 2'b01);
    chk("t4_err",   e, 1);
    chk("t4_rdata", rd, 32'hF1);
    @(negedge PCLK);
    chk("t4_idle", {PSEL, PENABLE, gnt, done, err}, 0);
    xfer(0, 0, ADDR_DATA1, 0, rd, e, lat, acc, ph);
    chk("t4_recover", rd, 32'hA5);
    chk("t4_rlat", lat, 3);

    // Unmapped read returns zero without error.
    xfer(0, 0, 32'h2000, 0, rd, e, lat, acc, ph);
    chk("t6_rdata", rd, 32'h0);
    chk("t6_err",   e, 0);

    // Reset during ACCESS (pointer is 1, so requester 1 owns the bus).
    stuck = 1;
    @(negedge PCLK);
    req_write = '0;
    req_addr  = {ADDR_DATA2, ADDR_DATA1};
    req = 2'b11;
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        ok = 1;
        break;
      end
    end
    chk("t5_access", ok, 1);
    chk("t5_pregnt", gnt, 2'b10);
    PRESET = 1'b1;
    #1;
    chk("t5_rst_bus", {PSEL, PENABLE, gnt, done}, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    stuck = 0;
    @(negedge PCLK);
    chk("t5_setup", {PSEL, PENABLE}, 2'b10);
    chk("t5_gnt0",  gnt, 2'b01);
    wait_done(0, ok);
    chk("t5_done0", ok, 1);
    chk("t5_rd0",   rdata, 32'hA5);
    req[0] = 1'b0;
    wait_done(1, ok);
    chk("t5_done1", ok, 1);
    chk("t5_rd1",   rdata, 32'hF1);
    req[1] = 1'b0;

    // Randomized traffic with random slave waits.
    ref_mem[0] = 32'hA5; ref_mem[1] = 32'hF1; ref_mem[2] = 32'h0;
    ptr_m = 0; busy = 0; stopping = 0; viol = 0; maxwait = 0; n_xfer = 0; cur_win = 0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
    rand_waits = 1;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge PCLK);
      if (cyc == 2000) stopping = 1;
      if (PSEL && !PENABLE && !busy) begin
        win = -1;
        for (int k = 0; k < NR; k++) begin
          c = (ptr_m + k) % NR;
          if (win < 0 && req[c]) win = c;
        end
        if (win < 0) begin
          viol++;
          win = 0;
        end
        chk("rnd_gnt",    gnt, onehot(win));
        chk("rnd_paddr",  PADDR, t_addr[win]);
        chk("rnd_pwrite", PWRITE, t_wr[win]);
        if (t_wr[win]) chk("rnd_pwdata", PWDATA, t_wd[win]);
        busy = 1;
        cur_win = win;
      end
      if (done != 0) begin
        if (!busy) begin
          viol++;
        end else begin
          chk("rnd_done", done, onehot(cur_win));
          chk("rnd_err",  err, 0);
          m = map_idx(t_addr[cur_win]);
          if (t_wr[cur_win]) begin
            if (m >= 0) ref_mem[m] = t_wd[cur_win];
          end else begin
            chk("rnd_rdata", rdata, (m >= 0) ? ref_mem[m] : 32'h0);
          end
          for (int k = 0; k < NR; k++) begin
            if (k != cur_win && req[k]) begin
              waitc[k]++;
              if (waitc[k] > maxwait) maxwait = waitc[k];
            end
          end
          waitc[cur_win] = 0;
          n_xfer++;
          ptr_m = (cur_win + 1) % NR;
          busy = 0;
          if (!stopping && $urandom_range(0, 1) == 1) new_txn(cur_win);
          else req[cur_win] = 1'b0;
        end
      end
      if (busy && gnt !== onehot(cur_win)) viol++;
      if (!busy && gnt !== '0) viol++;
      if (err && done == 0) viol++;
      if (busy && PSEL && PENABLE && PADDR !== t_addr[cur_win]) viol++;
      if (busy && PSEL && PENABLE) begin
        req_addr[cur_win*AW +: AW]  = $urandom;
        req_wdata[cur_win*DW +: DW] = $urandom;
        req_write[cur_win] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NR; i++)
        if (!req[i] && !stopping && $urandom_range(0, 3) == 0) new_txn(i);
      if (stopping && req == '0 && !busy) break;
    end
    chk("rnd_drain", {req, busy}, 0);
    chk("rnd_viol",  viol, 0);
    chk("rnd_fair",  maxwait <= NR, 1);
    chk("rnd_count", n_xfer > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
